// File: rtl/decode_issue.sv
// decode_issue: single-slot decode/issue stage with a register scoreboard.
//
// An instruction is accepted when none of its source registers, nor its
// destination register (if it writes one), is marked busy. An accepted
// instruction is held in the issue slot until the read stage takes it.
// Writing instructions mark their destination busy at issue, and the bit
// is cleared again by writeback. Cycles lost to hazards are counted in a
// saturating counter.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     fetch handshake; in_instr carries the instruction
//                         [31] no-write, [30:26] opcode, [25:21] rs/dest,
//                         [20:16] rt, [15:0] imm
//   out_valid/out_ready   issue handshake toward the register-file read stage
//   out_rs/out_rt         read addresses; out_dest/out_we write target
//   out_opcode/out_imm    opcode and immediate fields
//   wb_valid/wb_reg       writeback completion, clears the busy bit
//   flush                 drops the held issue slot
//   stall_cnt             saturating count of hazard-stall cycles
//
// Build option
//   DECODE_WB_BYPASS_EN   when defined, the register being written back in
//                         this cycle is treated as free by the hazard check,
//                         so a stalled instruction can issue in the wb cycle.
module decode_issue #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_rs,
  output logic [ADDR_W-1:0] out_rt,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_we,
  output logic [4:0]        out_opcode,
  output logic [15:0]       out_imm,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]   busy_q, busy_d, busy_eff;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d;
  logic              we_q, we_d;
  logic [4:0]        op_q, op_d;
  logic [15:0]       imm_q, imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              we_in;
  logic [ADDR_W-1:0] rs_in, rt_in;
  logic              hazard, accept;

  assign we_in = !in_instr[31];
  assign rs_in = in_instr[21 +: ADDR_W];
  assign rt_in = in_instr[16 +: ADDR_W];

`ifdef DECODE_WB_BYPASS_EN
  always_comb begin
    busy_eff = busy_q;
    if (wb_valid) busy_eff[wb_reg] = 1'b0;
  end
`else
  assign busy_eff = busy_q;
`endif

  // The destination is the rs field, so the dest term only matters when the
  // instruction writes; it is kept explicit for clarity.
  assign hazard = in_valid &&
                  (busy_eff[rs_in] || busy_eff[rt_in] || (we_in && busy_eff[rs_in]));

  assign in_ready = !rst && !hazard && (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    we_d    = we_q;
    op_d    = op_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;

    // Clear first so a same-cycle set of the same register wins.
    if (wb_valid) busy_d[wb_reg] = 1'b0;
    if (accept && we_in && (rs_in != '0)) busy_d[rs_in] = 1'b1;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      rs_d    = rs_in;
      rt_d    = rt_in;
      we_d    = we_in;
      op_d    = in_instr[30:26];
      imm_d   = in_instr[15:0];
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    if (hazard && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
      imm_q   <= '0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      we_q    <= we_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_rs     = rs_q;
  assign out_rt     = rt_q;
  assign out_dest   = rs_q;
  assign out_we     = we_q;
  assign out_opcode = op_q;
  assign out_imm    = imm_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_rs, out_rt, out_dest;
  logic        out_we;
  logic [4:0]  out_opcode;
  logic [15:0] out_imm;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest), .out_we(out_we),
    .out_opcode(out_opcode), .out_imm(out_imm), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .flush(flush), .stall_cnt(stall_cnt)
  );

`ifdef DECODE_WB_BYPASS_EN
  localparam int EXP_LAT = 0;
  localparam logic [15:0] EXP_CNT_AFTER_WB = 16'd3;
`else
  localparam int EXP_LAT = 1;
  localparam logic [15:0] EXP_CNT_AFTER_WB = 16'd4;
`endif

  typedef struct {
    logic        rst, iv;
    logic [31:0] instr;
    logic        ordy, wbv;
    logic [4:0]  wbr;
    logic        flush;
    logic        e_ir, e_ov;
    logic [4:0]  e_rs, e_rt;
    logic        e_we;
    logic [4:0]  e_op;
    logic [15:0] e_imm;
    logic [31:0] e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_err = 0;

  function automatic logic [31:0] ins(logic nw, logic [4:0] op, logic [4:0] rs,
                                      logic [4:0] rt, logic [15:0] imm);
    return {nw, op, rs, rt, imm};
  endfunction

  function automatic vec_t mkv(logic r, logic iv, logic [31:0] instr, logic ordy,
                               logic wbv, logic [4:0] wbr, logic fl, logic e_ir,
                               logic e_ov, logic [4:0] e_rs, logic [4:0] e_rt,
                               logic e_we, logic [4:0] e_op, logic [15:0] e_imm,
                               logic [31:0] e_busy, logic [15:0] e_cnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.instr = instr; v.ordy = ordy; v.wbv = wbv;
    v.wbr = wbr; v.flush = fl; v.e_ir = e_ir; v.e_ov = e_ov; v.e_rs = e_rs;
    v.e_rt = e_rt; v.e_we = e_we; v.e_op = e_op; v.e_imm = e_imm;
    v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle_in(logic r, logic iv, logic [31:0] instr, logic ordy,
                          logic wbv, logic [4:0] wbr, logic fl);
    @(negedge clk);
    rst = r; in_valid = iv; in_instr = instr; out_ready = ordy;
    wb_valid = wbv; wb_reg = wbr; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_rs"},    32'(out_rs),    32'd0);
    chk({tag, " out_rt"},    32'(out_rt),    32'd0);
    chk({tag, " out_dest"},  32'(out_dest),  32'd0);
    chk({tag, " out_we"},    32'(out_we),    32'd0);
    chk({tag, " out_opcode"},32'(out_opcode),32'd0);
    chk({tag, " out_imm"},   32'(out_imm),   32'd0);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, " busy"},      dut.busy_q,     32'd0);
  endtask

  logic [31:0] I1, I2, I3, I4, I5, I6, I7, I8;

  initial begin
    I1 = 32'h0443_0005;
    I2 = ins(1'b0, 5'd2, 5'd4,  5'd2,  16'h0007);
    I3 = ins(1'b0, 5'd3, 5'd6,  5'd7,  16'h0009);
    I4 = ins(1'b0, 5'd4, 5'd8,  5'd9,  16'h1234);
    I5 = ins(1'b0, 5'd5, 5'd5,  5'd1,  16'h00FF);
    I6 = ins(1'b0, 5'd6, 5'd0,  5'd3,  16'h0A0A);
    I7 = ins(1'b1, 5'd7, 5'd9,  5'd10, 16'h0001);
    I8 = ins(1'b0, 5'd8, 5'd5,  5'd11, 16'h0002);

    //                rst iv instr ordy wbv wbr fl | ir ov rs rt we op imm busy cnt
    tbl.push_back(mkv(1, 1, I1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'h0,    32'h0,  0));
    tbl.push_back(mkv(0, 1, I1, 1, 0, 0, 0,  1, 1, 2, 3, 1, 1, 16'h5,    32'h4,  0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mkv(0, 1, I3, 0, 0, 0, 0,  0, 1, 2, 3, 1, 1, 16'h5,  32'h4,  0));
    tbl.push_back(mkv(0, 1, I3, 1, 0, 0, 0,  1, 1, 6, 7, 1, 3, 16'h9,    32'h44, 0));
    tbl.push_back(mkv(0, 1, I4, 1, 0, 0, 1,  0, 0, 6, 7, 1, 3, 16'h9,    32'h44, 0));
    tbl.push_back(mkv(0, 0, I4, 1, 1, 6, 0,  1, 0, 6, 7, 1, 3, 16'h9,    32'h4,  0));
    tbl.push_back(mkv(0, 1, I5, 1, 1, 5, 0,  1, 1, 5, 1, 1, 5, 16'h00FF, 32'h24, 0));
    tbl.push_back(mkv(0, 1, I6, 1, 1, 2, 0,  1, 1, 0, 3, 1, 6, 16'h0A0A, 32'h20, 0));
    tbl.push_back(mkv(0, 1, I7, 1, 0, 0, 0,  1, 1, 9, 10, 0, 7, 16'h1,   32'h20, 0));
    tbl.push_back(mkv(0, 1, I8, 1, 0, 0, 0,  0, 0, 9, 10, 0, 7, 16'h1,   32'h20, 1));
    tbl.push_back(mkv(0, 0, I8, 1, 0, 0, 0,  1, 0, 9, 10, 0, 7, 16'h1,   32'h20, 1));
    tbl.push_back(mkv(0, 0, I8, 1, 1, 5, 0,  1, 0, 9, 10, 0, 7, 16'h1,   32'h0,  1));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_instr = tbl[i].instr;
      out_ready = tbl[i].ordy; wb_valid = tbl[i].wbv; wb_reg = tbl[i].wbr;
      flush = tbl[i].flush;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i),  32'(out_valid),  32'(tbl[i].e_ov));
      chk($sformatf("v%0d out_rs", i),     32'(out_rs),     32'(tbl[i].e_rs));
      chk($sformatf("v%0d out_rt", i),     32'(out_rt),     32'(tbl[i].e_rt));
      chk($sformatf("v%0d out_dest", i),   32'(out_dest),   32'(tbl[i].e_rs));
      chk($sformatf("v%0d out_we", i),     32'(out_we),     32'(tbl[i].e_we));
      chk($sformatf("v%0d out_opcode", i), 32'(out_opcode), 32'(tbl[i].e_op));
      chk($sformatf("v%0d out_imm", i),    32'(out_imm),    32'(tbl[i].e_imm));
      chk($sformatf("v%0d busy", i),       dut.busy_q,      tbl[i].e_busy);
      chk($sformatf("v%0d stall_cnt", i),  32'(stall_cnt),  32'(tbl[i].e_cnt));
    end

    // Stall on r2, count three cycles, then release through writeback.
    begin
      int lat;
      cycle_in(1, 0, '0, 1, 0, 0, 0);
      cycle_in(0, 1, I1, 1, 0, 0, 0);
      chk("wb busy r2 set", dut.busy_q, 32'h4);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        in_instr = I2;
        #1;
        chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("stall%0d stall_cnt", k), 32'(stall_cnt), 32'(k));
      end
      lat = -1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        wb_valid = (k == 0);
        wb_reg = 5'd2;
        #1;
        if (in_ready) begin
          lat = k;
          @(posedge clk);
          #1;
          break;
        end
        @(posedge clk);
      end
      wb_valid = 1'b0;
      chk("wb release latency", 32'(lat), 32'(EXP_LAT));
      chk("wb issue out_valid", 32'(out_valid), 32'd1);
      chk("wb issue out_rs", 32'(out_rs), 32'd4);
      chk("wb issue out_rt", 32'(out_rt), 32'd2);
      chk("wb issue busy", dut.busy_q, 32'h10);
      chk("wb issue stall_cnt", 32'(stall_cnt), 32'(EXP_CNT_AFTER_WB));
    end

    // Reset during a held (unconsumed) slot drops it.
    cycle_in(1, 0, '0, 1, 0, 0, 0);
    cycle_in(0, 1, I3, 0, 0, 0, 0);
    cycle_in(0, 0, I3, 0, 0, 0, 0);
    chk("hold out_valid", 32'(out_valid), 32'd1);
    cycle_in(1, 0, I3, 0, 0, 0, 0);
    chk_zero("rst hold");

    // Permanent hazard: counter saturates, then reset mid-stall clears all.
    cycle_in(0, 1, I1, 1, 0, 0, 0);
    @(negedge clk);
    in_instr = I2;
    repeat (100) @(posedge clk);
    #1;
    chk("sat stall_cnt 100", 32'(stall_cnt), 32'd100);
    repeat (65536 + 10 - 100) @(posedge clk);
    #1;
    chk("sat stall_cnt max", 32'(stall_cnt), 32'h0000_FFFF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk_zero("rst stall");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
